// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard/stall controller.
// master = datapath side (drives stage status), slave = controller side.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1_addr;
    logic [REG_ADDR_W-1:0] id_rs2_addr;
    logic                  id_uses_rs1;
    logic                  id_uses_rs2;
    logic                  ex_valid;
    logic [REG_ADDR_W-1:0] ex_rs1_addr;
    logic [REG_ADDR_W-1:0] ex_rs2_addr;
    logic [REG_ADDR_W-1:0] ex_rd_addr;
    logic                  ex_mem_read;
    logic                  ex_take_branch;
    logic                  mem_valid;
    logic [REG_ADDR_W-1:0] mem_rd_addr;
    logic                  mem_regwrite;
    logic                  mem_req;
    logic                  mem_ready;
    logic [REG_ADDR_W-1:0] wb_rd_addr;
    logic                  wb_regwrite;
    logic [1:0]            forward_a;
    logic [1:0]            forward_b;
    logic                  stall_all;
    logic                  stall_front;
    logic                  bubble_id_ex;
    logic                  flush_if_id;
    logic                  bubble_mem_wb;
    logic                  mem_timeout_err;
    logic [CNT_W-1:0]      perf_stall_mem;
    logic [CNT_W-1:0]      perf_load_use;
    logic [CNT_W-1:0]      perf_flush;

    modport master (
        output id_valid, id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
        output ex_valid, ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_mem_read, ex_take_branch,
        output mem_valid, mem_rd_addr, mem_regwrite, mem_req, mem_ready,
        output wb_rd_addr, wb_regwrite,
        input  forward_a, forward_b, stall_all, stall_front, bubble_id_ex,
        input  flush_if_id, bubble_mem_wb, mem_timeout_err,
        input  perf_stall_mem, perf_load_use, perf_flush
    );

    modport slave (
        input  id_valid, id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
        input  ex_valid, ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_mem_read, ex_take_branch,
        input  mem_valid, mem_rd_addr, mem_regwrite, mem_req, mem_ready,
        input  wb_rd_addr, wb_regwrite,
        output forward_a, forward_b, stall_all, stall_front, bubble_id_ex,
        output flush_if_id, bubble_mem_wb, mem_timeout_err,
        output perf_stall_mem, perf_load_use, perf_flush
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage RV32 pipeline: forwarding, load-use interlock,
// branch flush and data-memory wait FSM with timeout abort. Optional macro: PERF_COUNTERS_EN.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input logic                   clk,
    input logic                   rst,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam int WAIT_CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_V = WAIT_CNT_W'(MEM_TIMEOUT);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    mem_state_e            state_q, state_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic                  timeout_err_q, timeout_err_d;

    logic       load_use_s;
    logic       branch_s;
    logic       stall_mem_s;
    logic       abort_s;
    logic       stall_front_s;
    logic       bubble_id_ex_s;
    logic       flush_if_id_s;
    logic       bubble_mem_wb_s;
    logic [1:0] forward_a_s;
    logic [1:0] forward_b_s;

    // EX/MEM beats WB; x0 is hard-wired zero so it is never a forwarding source.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] src,
        input logic                  mem_ok,
        input logic [REG_ADDR_W-1:0] mem_rd,
        input logic                  wb_ok,
        input logic [REG_ADDR_W-1:0] wb_rd
    );
        logic [1:0] sel;
        if (mem_ok && (mem_rd != {REG_ADDR_W{1'b0}}) && (mem_rd == src)) begin
            sel = 2'b10;
        end else if (wb_ok && (wb_rd != {REG_ADDR_W{1'b0}}) && (wb_rd == src)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Forwarding selects and raw hazard detection.
    always_comb begin
        forward_a_s = fwd_sel(hz.ex_rs1_addr, hz.mem_valid & hz.mem_regwrite, hz.mem_rd_addr,
                              hz.wb_regwrite, hz.wb_rd_addr);
        forward_b_s = fwd_sel(hz.ex_rs2_addr, hz.mem_valid & hz.mem_regwrite, hz.mem_rd_addr,
                              hz.wb_regwrite, hz.wb_rd_addr);
        load_use_s  = hz.ex_valid & hz.ex_mem_read & (hz.ex_rd_addr != {REG_ADDR_W{1'b0}}) &
                      hz.id_valid &
                      ((hz.id_uses_rs1 & (hz.id_rs1_addr == hz.ex_rd_addr)) |
                       (hz.id_uses_rs2 & (hz.id_rs2_addr == hz.ex_rd_addr)));
        branch_s    = hz.ex_valid & hz.ex_take_branch;
    end

    // Memory wait FSM: next state, wait counter, stall and abort decisions.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        stall_mem_s   = 1'b0;
        abort_s       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hz.mem_valid && hz.mem_req && !hz.mem_ready) begin
                    stall_mem_s = 1'b1;
                    state_d     = ST_WAIT;
                    wait_cnt_d  = WAIT_CNT_W'(1);
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (hz.mem_ready) begin
                    state_d    = ST_IDLE;
                    wait_cnt_d = {WAIT_CNT_W{1'b0}};
                end else if (wait_cnt_q < TIMEOUT_V) begin
                    stall_mem_s = 1'b1;
                    wait_cnt_d  = wait_cnt_q + WAIT_CNT_W'(1);
                end else begin
                    abort_s    = 1'b1;
                    state_d    = ST_IDLE;
                    wait_cnt_d = {WAIT_CNT_W{1'b0}};
                end
            end
            default: begin
                state_d    = ST_IDLE;
                wait_cnt_d = {WAIT_CNT_W{1'b0}};
            end
        endcase
        timeout_err_d = timeout_err_q | abort_s;
    end

    // A global memory stall masks every other pipeline action; held hazards re-evaluate on release.
    always_comb begin
        stall_front_s   = 1'b0;
        bubble_id_ex_s  = 1'b0;
        flush_if_id_s   = 1'b0;
        bubble_mem_wb_s = 1'b0;
        if (stall_mem_s) begin
            stall_front_s = 1'b1;
        end else begin
            flush_if_id_s   = branch_s;
            bubble_id_ex_s  = branch_s | load_use_s;
            stall_front_s   = load_use_s & ~branch_s;
            bubble_mem_wb_s = abort_s;
        end
    end

    // FSM state, wait counter and sticky timeout flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            wait_cnt_q    <= {WAIT_CNT_W{1'b0}};
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

`ifdef PERF_COUNTERS_EN
    logic [CNT_W-1:0] perf_stall_mem_q, perf_load_use_q, perf_flush_q;
    logic             load_use_evt_s;

    assign load_use_evt_s = load_use_s & ~branch_s & ~stall_mem_s;

    // Saturating event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_mem_q <= {CNT_W{1'b0}};
            perf_load_use_q  <= {CNT_W{1'b0}};
            perf_flush_q     <= {CNT_W{1'b0}};
        end else begin
            if (stall_mem_s && (perf_stall_mem_q != {CNT_W{1'b1}})) begin
                perf_stall_mem_q <= perf_stall_mem_q + CNT_W'(1);
            end else begin
                perf_stall_mem_q <= perf_stall_mem_q;
            end
            if (load_use_evt_s && (perf_load_use_q != {CNT_W{1'b1}})) begin
                perf_load_use_q <= perf_load_use_q + CNT_W'(1);
            end else begin
                perf_load_use_q <= perf_load_use_q;
            end
            if (flush_if_id_s && (perf_flush_q != {CNT_W{1'b1}})) begin
                perf_flush_q <= perf_flush_q + CNT_W'(1);
            end else begin
                perf_flush_q <= perf_flush_q;
            end
        end
    end

    assign hz.perf_stall_mem = perf_stall_mem_q;
    assign hz.perf_load_use  = perf_load_use_q;
    assign hz.perf_flush     = perf_flush_q;
`else
    assign hz.perf_stall_mem = {CNT_W{1'b0}};
    assign hz.perf_load_use  = {CNT_W{1'b0}};
    assign hz.perf_flush     = {CNT_W{1'b0}};
`endif

    assign hz.forward_a       = forward_a_s;
    assign hz.forward_b       = forward_b_s;
    assign hz.stall_all       = stall_mem_s;
    assign hz.stall_front     = stall_front_s;
    assign hz.bubble_id_ex    = bubble_id_ex_s;
    assign hz.flush_if_id     = flush_if_id_s;
    assign hz.bubble_mem_wb   = bubble_mem_wb_s;
    assign hz.mem_timeout_err = timeout_err_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (MEM_TIMEOUT = 4, default build).
module tb_pipeline_hazard_ctrl;
    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    pipeline_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(32)) hz ();

    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        hz.id_valid = 1'b0; hz.id_rs1_addr = 5'd0; hz.id_rs2_addr = 5'd0;
        hz.id_uses_rs1 = 1'b0; hz.id_uses_rs2 = 1'b0;
        hz.ex_valid = 1'b0; hz.ex_rs1_addr = 5'd0; hz.ex_rs2_addr = 5'd0; hz.ex_rd_addr = 5'd0;
        hz.ex_mem_read = 1'b0; hz.ex_take_branch = 1'b0;
        hz.mem_valid = 1'b0; hz.mem_rd_addr = 5'd0; hz.mem_regwrite = 1'b0;
        hz.mem_req = 1'b0; hz.mem_ready = 1'b0;
        hz.wb_rd_addr = 5'd0; hz.wb_regwrite = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (hz.stall_all !== 1'b0 || hz.stall_front !== 1'b0 || hz.bubble_id_ex !== 1'b0 ||
            hz.flush_if_id !== 1'b0 || hz.bubble_mem_wb !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl got stall_all=%b stall_front=%b bub=%b flush=%b bubwb=%b exp all 0",
                     hz.stall_all, hz.stall_front, hz.bubble_id_ex, hz.flush_if_id, hz.bubble_mem_wb);
        end
        tests_run++;
        if (hz.mem_timeout_err !== 1'b0 || hz.forward_a !== 2'b00 || hz.forward_b !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_state got err=%b fa=%b fb=%b exp 0 00 00",
                     hz.mem_timeout_err, hz.forward_a, hz.forward_b);
        end
        tests_run++;
        if (hz.perf_stall_mem !== 32'd0 || hz.perf_load_use !== 32'd0 || hz.perf_flush !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_perf got %0d %0d %0d exp 0 0 0",
                     hz.perf_stall_mem, hz.perf_load_use, hz.perf_flush);
        end
        next_cycle();
    endtask

    task automatic test_load_use();
        // Load x5 in EX, consumer of x5 in ID.
        clear_inputs();
        hz.ex_valid = 1'b1; hz.ex_mem_read = 1'b1; hz.ex_rd_addr = 5'd5;
        hz.id_valid = 1'b1; hz.id_uses_rs1 = 1'b1; hz.id_rs1_addr = 5'd5;
        @(negedge clk);
        tests_run++;
        if (hz.stall_front !== 1'b1 || hz.bubble_id_ex !== 1'b1 || hz.flush_if_id !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_use_stall got sf=%b bub=%b flush=%b exp 1 1 0",
                     hz.stall_front, hz.bubble_id_ex, hz.flush_if_id);
        end
        next_cycle();
        // Bubble in EX, load in MEM completing immediately.
        clear_inputs();
        hz.id_valid = 1'b1; hz.id_uses_rs1 = 1'b1; hz.id_rs1_addr = 5'd5;
        hz.mem_valid = 1'b1; hz.mem_rd_addr = 5'd5; hz.mem_regwrite = 1'b1;
        hz.mem_req = 1'b1; hz.mem_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (hz.stall_front !== 1'b0 || hz.bubble_id_ex !== 1'b0 || hz.stall_all !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_use_release got sf=%b bub=%b sa=%b exp 0 0 0",
                     hz.stall_front, hz.bubble_id_ex, hz.stall_all);
        end
        next_cycle();
        // Consumer in EX, load in WB.
        clear_inputs();
        hz.ex_valid = 1'b1; hz.ex_rs1_addr = 5'd5;
        hz.wb_rd_addr = 5'd5; hz.wb_regwrite = 1'b1;
        @(negedge clk);
        tests_run++;
        if (hz.forward_a !== 2'b01 || hz.forward_b !== 2'b00) begin
            tests_failed++;
            $display("FAIL load_use_fwd_wb got fa=%b fb=%b exp 01 00", hz.forward_a, hz.forward_b);
        end
        next_cycle();
        // rs2 match counts only when rs2 is actually read; rd=x0 never interlocks.
        clear_inputs();
        hz.ex_valid = 1'b1; hz.ex_mem_read = 1'b1; hz.ex_rd_addr = 5'd7;
        hz.id_valid = 1'b1; hz.id_rs2_addr = 5'd7; hz.id_uses_rs2 = 1'b0;
        @(negedge clk);
        tests_run++;
        if (hz.stall_front !== 1'b0 || hz.bubble_id_ex !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_use_unused_rs2 got sf=%b bub=%b exp 0 0", hz.stall_front, hz.bubble_id_ex);
        end
        hz.id_uses_rs2 = 1'b1;
        #1;
        tests_run++;
        if (hz.stall_front !== 1'b1 || hz.bubble_id_ex !== 1'b1) begin
            tests_failed++;
            $display("FAIL load_use_rs2 got sf=%b bub=%b exp 1 1", hz.stall_front, hz.bubble_id_ex);
        end
        hz.ex_rd_addr = 5'd0; hz.id_rs2_addr = 5'd0;
        #1;
        tests_run++;
        if (hz.stall_front !== 1'b0 || hz.bubble_id_ex !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_use_x0 got sf=%b bub=%b exp 0 0", hz.stall_front, hz.bubble_id_ex);
        end
        next_cycle();
    endtask

    task automatic test_forwarding();
        clear_inputs();
        hz.ex_valid = 1'b1; hz.ex_rs1_addr = 5'd3; hz.ex_rs2_addr = 5'd3;
        hz.mem_valid = 1'b1; hz.mem_rd_addr = 5'd3; hz.mem_regwrite = 1'b1;
        hz.wb_rd_addr = 5'd3; hz.wb_regwrite = 1'b1;
        @(negedge clk);
        tests_run++;
        if (hz.forward_a !== 2'b10 || hz.forward_b !== 2'b10) begin
            tests_failed++;
            $display("FAIL fwd_mem_wins got fa=%b fb=%b exp 10 10", hz.forward_a, hz.forward_b);
        end
        hz.mem_valid = 1'b0;
        #1;
        tests_run++;
        if (hz.forward_a !== 2'b01 || hz.forward_b !== 2'b01) begin
            tests_failed++;
            $display("FAIL fwd_mem_invalid got fa=%b fb=%b exp 01 01", hz.forward_a, hz.forward_b);
        end
        hz.mem_valid = 1'b1; hz.mem_regwrite = 1'b0; hz.ex_rs2_addr = 5'd9;
        #1;
        tests_run++;
        if (hz.forward_a !== 2'b01 || hz.forward_b !== 2'b00) begin
            tests_failed++;
            $display("FAIL fwd_no_regwrite got fa=%b fb=%b exp 01 00", hz.forward_a, hz.forward_b);
        end
        hz.mem_regwrite = 1'b1; hz.mem_rd_addr = 5'd0; hz.wb_rd_addr = 5'd0; hz.ex_rs1_addr = 5'd0;
        #1;
        tests_run++;
        if (hz.forward_a !== 2'b00) begin
            tests_failed++;
            $display("FAIL fwd_x0 got fa=%b exp 00", hz.forward_a);
        end
        next_cycle();
    endtask

    task automatic test_branch();
        clear_inputs();
        hz.ex_valid = 1'b1; hz.ex_take_branch = 1'b1; hz.ex_mem_read = 1'b1; hz.ex_rd_addr = 5'd4;
        hz.id_valid = 1'b1; hz.id_uses_rs1 = 1'b1; hz.id_rs1_addr = 5'd4;
        @(negedge clk);
        tests_run++;
        if (hz.flush_if_id !== 1'b1 || hz.bubble_id_ex !== 1'b1 || hz.stall_front !== 1'b0) begin
            tests_failed++;
            $display("FAIL branch_over_load_use got flush=%b bub=%b sf=%b exp 1 1 0",
                     hz.flush_if_id, hz.bubble_id_ex, hz.stall_front);
        end
        next_cycle();
    endtask

    task automatic test_mem_wait();
        clear_inputs();
        hz.mem_valid = 1'b1; hz.mem_req = 1'b1; hz.mem_ready = 1'b0;
        hz.ex_valid = 1'b1; hz.ex_take_branch = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (hz.stall_all !== 1'b1 || hz.stall_front !== 1'b1 ||
                hz.flush_if_id !== 1'b0 || hz.bubble_id_ex !== 1'b0) begin
                tests_failed++;
                $display("FAIL mem_wait_stall[%0d] got sa=%b sf=%b flush=%b bub=%b exp 1 1 0 0",
                         i, hz.stall_all, hz.stall_front, hz.flush_if_id, hz.bubble_id_ex);
            end
            next_cycle();
        end
        hz.mem_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (hz.stall_all !== 1'b0 || hz.flush_if_id !== 1'b1 || hz.bubble_mem_wb !== 1'b0) begin
            tests_failed++;
            $display("FAIL mem_wait_release got sa=%b flush=%b bubwb=%b exp 0 1 0",
                     hz.stall_all, hz.flush_if_id, hz.bubble_mem_wb);
        end
        next_cycle();
        // Back in IDLE: a fresh ready access never stalls.
        hz.ex_take_branch = 1'b0;
        @(negedge clk);
        tests_run++;
        if (hz.stall_all !== 1'b0 || hz.stall_front !== 1'b0) begin
            tests_failed++;
            $display("FAIL mem_wait_idle got sa=%b sf=%b exp 0 0", hz.stall_all, hz.stall_front);
        end
        next_cycle();
    endtask

    task automatic test_timeout();
        clear_inputs();
        hz.mem_valid = 1'b1; hz.mem_req = 1'b1; hz.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests_run++;
            if (hz.stall_all !== 1'b1 || hz.bubble_mem_wb !== 1'b0 || hz.mem_timeout_err !== 1'b0) begin
                tests_failed++;
                $display("FAIL timeout_stall[%0d] got sa=%b bubwb=%b err=%b exp 1 0 0",
                         i, hz.stall_all, hz.bubble_mem_wb, hz.mem_timeout_err);
            end
            next_cycle();
        end
        @(negedge clk);
        tests_run++;
        if (hz.stall_all !== 1'b0 || hz.bubble_mem_wb !== 1'b1 || hz.stall_front !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_abort got sa=%b bubwb=%b sf=%b exp 0 1 0",
                     hz.stall_all, hz.bubble_mem_wb, hz.stall_front);
        end
        next_cycle();
        clear_inputs();
        repeat (3) next_cycle();
        @(negedge clk);
        tests_run++;
        if (hz.mem_timeout_err !== 1'b1 || hz.bubble_mem_wb !== 1'b0 || hz.stall_all !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_sticky got err=%b bubwb=%b sa=%b exp 1 0 0",
                     hz.mem_timeout_err, hz.bubble_mem_wb, hz.stall_all);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_wait();
        clear_inputs();
        hz.mem_valid = 1'b1; hz.mem_req = 1'b1; hz.mem_ready = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        #1 rst = 1'b1;
        clear_inputs();
        #1;
        tests_run++;
        if (hz.stall_all !== 1'b0 || hz.mem_timeout_err !== 1'b0 || hz.perf_stall_mem !== 32'd0 ||
            hz.perf_load_use !== 32'd0 || hz.perf_flush !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_wait got sa=%b err=%b perf=%0d/%0d/%0d exp 0 0 0/0/0",
                     hz.stall_all, hz.mem_timeout_err, hz.perf_stall_mem, hz.perf_load_use, hz.perf_flush);
        end
        next_cycle();
        rst = 1'b0;
        // FSM restarted from IDLE: a ready access completes with no stall.
        hz.mem_valid = 1'b1; hz.mem_req = 1'b1; hz.mem_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (hz.stall_all !== 1'b0 || hz.bubble_mem_wb !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_fsm_idle got sa=%b bubwb=%b exp 0 0", hz.stall_all, hz.bubble_mem_wb);
        end
        next_cycle();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b0;
        clear_inputs();
        #1;
        test_reset();
        test_load_use();
        test_forwarding();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
